// File: rtl/elut_config_loader.sv
// ============================================================================
// elut_config_loader
// ----------------------------------------------------------------------------
// Configuration-time write controller for the overlay's LUTRAM cells. A stream
// of 32-bit configuration words arrives over a valid/ready handshake and is
// serialised into one-bit writes on the shared LUT write port. Each LUT takes
// two words: the low word fills addresses 0..31 and the high word fills
// addresses 32..63, LSB first. Loading all NUM_LUTS truth tables is one
// transaction, opened by `start` and closed by a single-cycle `done` pulse.
//
// Parameters
//   NUM_LUTS   number of LUTRAM cells driven (1..256)
//   IDX_W      width of the LUT index counter, 2**IDX_W >= NUM_LUTS
//
// Ports
//   clk        in   single clock, also the LUTRAM write clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a full load (only looked at while idle)
//   abort      in   cancel the load in progress (looked at in every state)
//   cfg_data   in   32-bit configuration word
//   cfg_valid  in   cfg_data is valid
//   cfg_ready  out  loader accepts a word this cycle
//   lut_a      out  6-bit write address broadcast to every LUT
//   lut_d      out  write data bit broadcast to every LUT
//   lut_we     out  one-hot write enable, bit i drives LUT i
//   busy       out  a load is in progress
//   done       out  one-cycle pulse when a load completes
//
// Every output is a flop. The next-state logic also computes the value each
// output must carry in the coming state, so lut_we/lut_a/lut_d always change
// together on the same edge and the LUTRAM captures a coherent triple.
// ============================================================================
module elut_config_loader #(
    parameter int NUM_LUTS = 16,
    parameter int IDX_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [31:0]         cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [5:0]          lut_a,
    output logic                lut_d,
    output logic [NUM_LUTS-1:0] lut_we,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

    state_t                state, state_d;
    logic [IDX_W-1:0]      lut_idx, lut_idx_d;
    logic                  half, half_d;
    logic [4:0]            bit_cnt, bit_cnt_d;
    logic [31:0]           shreg, shreg_d;

    logic                  cfg_ready_d;
    logic [5:0]            lut_a_d;
    logic                  lut_d_d;
    logic [NUM_LUTS-1:0]   lut_we_d;
    logic                  busy_d;
    logic                  done_d;

    // Next-state logic for the sequencer and the registered outputs. The
    // output values are derived from the *next* state and counters so that
    // the flops present, during a WRITE cycle, exactly the LUT, address and
    // data bit belonging to that cycle. Abort is applied last so it wins over
    // start and over a handshake on the same edge.
    always_comb begin
        state_d     = state;
        lut_idx_d   = lut_idx;
        half_d      = half;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;

        cfg_ready_d = 1'b0;
        lut_a_d     = '0;
        lut_d_d     = 1'b0;
        lut_we_d    = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    lut_idx_d = '0;
                    half_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end

            LOAD: begin
                if (cfg_valid && cfg_ready) begin
                    shreg_d   = cfg_data;
                    bit_cnt_d = '0;
                    state_d   = WRITE;
                end
            end

            WRITE: begin
                shreg_d   = {1'b0, shreg[31:1]};
                bit_cnt_d = bit_cnt + 5'd1;
                // Last bit of the word: either fetch the high word of the
                // same LUT, move to the next LUT, or finish after the last.
                if (bit_cnt == 5'd31) begin
                    if (!half) begin
                        half_d  = 1'b1;
                        state_d = LOAD;
                    end else if (lut_idx != LAST_IDX) begin
                        lut_idx_d = lut_idx + IDX_W'(1);
                        half_d    = 1'b0;
                        state_d   = LOAD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d   = IDLE;
            lut_idx_d = '0;
            half_d    = 1'b0;
            bit_cnt_d = '0;
            shreg_d   = '0;
        end

        cfg_ready_d = (state_d == LOAD);
        busy_d      = (state_d == LOAD) || (state_d == WRITE);
        done_d      = (state_d == FIN);

        // Write port is only ever active in WRITE, so a handshake cycle can
        // never coincide with a LUT write.
        if (state_d == WRITE) begin
            for (int i = 0; i < NUM_LUTS; i++) begin
                lut_we_d[i] = (lut_idx_d == IDX_W'(i));
            end
            lut_a_d = {half_d, bit_cnt_d};
            lut_d_d = shreg_d[0];
        end
    end

    // State, counters, shift register and output flops. Reset drops all of
    // them immediately; LUT contents already written are not touched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lut_idx   <= '0;
            half      <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cfg_ready <= 1'b0;
            lut_a     <= '0;
            lut_d     <= 1'b0;
            lut_we    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            lut_idx   <= lut_idx_d;
            half      <= half_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            cfg_ready <= cfg_ready_d;
            lut_a     <= lut_a_d;
            lut_d     <= lut_d_d;
            lut_we    <= lut_we_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_elut_config_loader.sv
// ============================================================================
// tb_elut_config_loader
// ----------------------------------------------------------------------------
// Self-checking bench for elut_config_loader with four LUTs. A behavioural
// LUTRAM model records every write the loader issues; the expected contents
// of LUT i are simply {word[2i+1], word[2i]}, and the expected completion
// edge is 1 + 66*NUM_LUTS plus one edge per stalled LOAD cycle.
// ============================================================================
module tb_elut_config_loader;

    localparam int NUM_LUTS = 4;
    localparam int IDX_W    = 8;
    localparam int NWORDS   = 2 * NUM_LUTS;
    localparam int WRITES   = NWORDS * 32;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [31:0]         cfg_data;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [5:0]          lut_a;
    logic                lut_d;
    logic [NUM_LUTS-1:0] lut_we;
    logic                busy;
    logic                done;

    int                  checks   = 0;
    int                  failures = 0;

    logic [31:0]         words  [NWORDS];
    int                  stalls [NWORDS];

    logic                mem_clear;
    logic [63:0]         lut_mem [NUM_LUTS];

    elut_config_loader #(
        .NUM_LUTS (NUM_LUTS),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .lut_a     (lut_a),
        .lut_d     (lut_d),
        .lut_we    (lut_we),
        .busy      (busy),
        .done      (done)
    );

    // 100 MHz style clock, first rising edge at 5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural LUTRAM array: each LUT captures lut_d at lut_a on any edge
    // where its write enable is high.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < NUM_LUTS; i++) lut_mem[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LUTS; i++) begin
                if (lut_we[i]) lut_mem[i][lut_a] <= lut_d;
            end
        end
    end

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        @(negedge clk);
        mem_clear = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;
    endtask

    // Runs one complete load using words[] and stalls[] and checks timing,
    // write count, one-hotness, busy coverage and the resulting contents.
    // With start_noise set, spurious start pulses are thrown in while busy.
    task automatic applyStimulus(input string tag, input bit start_noise);
        int edge_num;
        int exp_done;
        int done_edge;
        int wi;
        int stall_left;
        int pulses;
        int bad_hot;
        int busy_gap;
        bit got_done;
        bit ready_seen;

        clearModel();
        exp_done = 1 + NUM_LUTS * 66;
        for (int i = 0; i < NWORDS; i++) exp_done += stalls[i];

        done_edge  = -1;
        wi         = 0;
        stall_left = stalls[0];
        pulses     = 0;
        bad_hot    = 0;
        busy_gap   = 0;
        got_done   = 1'b0;

        start     = 1'b1;
        cfg_valid = 1'b0;
        @(posedge clk);
        edge_num = 1;
        @(negedge clk);
        start = 1'b0;

        while (!got_done && edge_num < exp_done + 64) begin
            if (done) begin
                got_done  = 1'b1;
                done_edge = edge_num;
            end else begin
                if (!busy) busy_gap++;
                if (lut_we != '0) pulses++;
                if (!$onehot0(lut_we)) bad_hot++;
                ready_seen = cfg_ready;
                cfg_valid  = (stall_left == 0);
                if (wi < NWORDS) cfg_data = words[wi];
                else             cfg_data = $urandom();
                if (ready_seen && stall_left > 0) stall_left--;
                start = start_noise && ($urandom_range(0, 7) == 0);
                @(posedge clk);
                edge_num++;
                if (ready_seen && cfg_valid) begin
                    wi++;
                    stall_left = (wi < NWORDS) ? stalls[wi] : 0;
                end
                @(negedge clk);
            end
        end

        checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        start     = 1'b0;
        cfg_valid = 1'b0;

        checkOutput({tag, "_done_seen"}, 64'(got_done), 64'd1);
        checkOutput({tag, "_done_edge"}, 64'(done_edge), 64'(exp_done));
        checkOutput({tag, "_we_pulses"}, 64'(pulses), 64'(WRITES));
        checkOutput({tag, "_we_not_onehot"}, 64'(bad_hot), 64'd0);
        checkOutput({tag, "_busy_gaps"}, 64'(busy_gap), 64'd0);
        checkOutput({tag, "_words_taken"}, 64'(wi), 64'(NWORDS));
        for (int i = 0; i < NUM_LUTS; i++) begin
            checkOutput($sformatf("%s_lut%0d", tag, i), lut_mem[i],
                        {words[2*i+1], words[2*i]});
        end

        @(negedge clk);
        checkOutput({tag, "_done_single"}, 64'(done), 64'd0);
        checkOutput({tag, "_idle_ready"}, 64'(cfg_ready), 64'd0);
    endtask

    initial begin
        int  bad;
        bit  found;

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        mem_clear = 1'b0;

        // Reset values of every output.
        @(negedge clk);
        checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        checkOutput("rst_lut_a",     64'(lut_a),     64'd0);
        checkOutput("rst_lut_d",     64'(lut_d),     64'd0);
        checkOutput("rst_lut_we",    64'(lut_we),    64'd0);
        checkOutput("rst_busy",      64'(busy),      64'd0);
        checkOutput("rst_done",      64'(done),      64'd0);
        #2 rst_n = 1'b1;

        // Words offered while idle are never accepted.
        $display("[TB] idle valid");
        bad       = 0;
        cfg_valid = 1'b1;
        repeat (6) begin
            cfg_data = $urandom();
            @(negedge clk);
            if (cfg_ready || busy || done || (lut_we != '0)) bad++;
        end
        cfg_valid = 1'b0;
        checkOutput("idle_valid_ignored", 64'(bad), 64'd0);

        // Full load with valid held high.
        $display("[TB] full load");
        for (int i = 0; i < NUM_LUTS; i++) begin
            words[2*i]   = 32'hA5A5A5A5 ^ 32'(i);
            words[2*i+1] = 32'h0000FFFF;
        end
        for (int i = 0; i < NWORDS; i++) stalls[i] = 0;
        applyStimulus("full", 1'b0);

        // Same words with three idle cycles before each, plus stray starts.
        $display("[TB] stalled load");
        for (int i = 0; i < NWORDS; i++) stalls[i] = 3;
        applyStimulus("stall", 1'b1);

        // Bit order: only address 0 and address 63 set in every LUT.
        $display("[TB] bit order");
        for (int i = 0; i < NUM_LUTS; i++) begin
            words[2*i]   = 32'h00000001;
            words[2*i+1] = 32'h80000000;
        end
        for (int i = 0; i < NWORDS; i++) stalls[i] = 0;
        applyStimulus("bitorder", 1'b0);

        // Randomised words and stall patterns.
        for (int r = 0; r < 3; r++) begin
            $display("[TB] random load %0d", r);
            for (int i = 0; i < NWORDS; i++) begin
                words[i]  = $urandom();
                stalls[i] = $urandom_range(0, 4);
            end
            applyStimulus($sformatf("rand%0d", r), 1'b1);
        end

        // Abort during the write of address 40 of LUT 1.
        $display("[TB] abort");
        clearModel();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        cfg_valid = 1'b1;
        found     = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            if (lut_we == 4'b0010 && lut_a == 6'd40) begin
                found = 1'b1;
            end else begin
                cfg_data = $urandom();
                @(negedge clk);
            end
        end
        checkOutput("abort_point_reached", 64'(found), 64'd1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_we",    64'(lut_we),    64'd0);
        checkOutput("abort_busy",  64'(busy),      64'd0);
        checkOutput("abort_done",  64'(done),      64'd0);
        checkOutput("abort_ready", 64'(cfg_ready), 64'd0);
        bad = 0;
        repeat (8) begin
            cfg_data = $urandom();
            @(negedge clk);
            if (cfg_ready || busy || done || (lut_we != '0)) bad++;
        end
        cfg_valid = 1'b0;
        checkOutput("abort_stays_idle", 64'(bad), 64'd0);
        for (int i = 0; i < NWORDS; i++) begin
            words[i]  = $urandom();
            stalls[i] = 0;
        end
        applyStimulus("after_abort", 1'b0);

        // Asynchronous reset in the middle of LUT 0's high word.
        $display("[TB] async reset");
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        cfg_valid = 1'b1;
        repeat (50) begin
            cfg_data = $urandom();
            @(negedge clk);
        end
        checkOutput("arst_pre_we", 64'(lut_we), 64'(4'b0001));
        checkOutput("arst_pre_a",  64'(lut_a),  64'd48);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_cfg_ready", 64'(cfg_ready), 64'd0);
        checkOutput("arst_lut_a",     64'(lut_a),     64'd0);
        checkOutput("arst_lut_d",     64'(lut_d),     64'd0);
        checkOutput("arst_lut_we",    64'(lut_we),    64'd0);
        checkOutput("arst_busy",      64'(busy),      64'd0);
        checkOutput("arst_done",      64'(done),      64'd0);
        cfg_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < NWORDS; i++) begin
            words[i]  = $urandom();
            stalls[i] = $urandom_range(0, 2);
        end
        applyStimulus("after_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
